// File: rtl/seq_decoder_pkg.sv
// Shared definitions for the sequenced decoder.
// Mode encodings and output-width helper.
package seq_decoder_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_THERMO = 2'b01,
    MODE_SCAN   = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_t;

  function automatic int outs_of(input int width);
    return 1 << width;
  endfunction

endpackage

// File: rtl/seq_decoder_decode_core.sv
// Combinational one-hot / thermometer decoder.
// thermo=1 sets bits [index:0], else only bit index.
module decode_core #(
  parameter  int WIDTH = 3,
  localparam int OUTS  = 2**WIDTH
) (
  input  logic [WIDTH-1:0] index,
  input  logic             thermo,
  output logic [OUTS-1:0]  bits
);

  always_comb begin
    bits = '0;
    for (int i = 0; i < OUTS; i++) begin
      if (thermo) begin
        bits[i] = (i <= int'(index));
      end else begin
        bits[i] = (i == int'(index));
      end
    end
  end

endmodule

// File: rtl/seq_decoder.sv
// Handshaked decoder with scan counter.
// One-deep output register; drain and refill in one cycle.
module seq_decoder
  import seq_decoder_pkg::*;
#(
  parameter  int WIDTH = 3,
  localparam int OUTS  = outs_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sel,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUTS-1:0]  x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             scan_wrap
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_d;
  logic [OUTS-1:0]  x_d;
  logic             ov_d;
  logic             wrap_d;
  logic [WIDTH-1:0] index;
  logic [OUTS-1:0]  bits;
  logic             accept;
  logic             is_scan;
  logic             is_load;
  logic             is_thermo;
  mode_t            m;

  assign m         = mode_t'(mode);
  assign is_scan   = (m == MODE_SCAN);
  assign is_load   = (m == MODE_LOAD);
  assign is_thermo = (m == MODE_THERMO);

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign index    = is_scan ? cnt : sel;

  decode_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .index (index),
    .thermo(is_thermo),
    .bits  (bits)
  );

  // A drain clears valid unless a new result lands in the same cycle.
  always_comb begin
    x_d    = x;
    ov_d   = out_valid;
    wrap_d = scan_wrap;
    cnt_d  = cnt;
    if (out_ready) begin
      ov_d = 1'b0;
    end
    if (accept) begin
      unique case (1'b1)
        is_load: begin
          cnt_d = sel;
        end
        is_scan: begin
          cnt_d  = cnt + 1'b1;
          x_d    = bits;
          ov_d   = 1'b1;
          wrap_d = (cnt == CNT_MAX);
        end
        default: begin
          x_d    = bits;
          ov_d   = 1'b1;
          wrap_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= '0;
      out_valid <= 1'b0;
      scan_wrap <= 1'b0;
      cnt       <= '0;
    end else begin
      x         <= x_d;
      out_valid <= ov_d;
      scan_wrap <= wrap_d;
      cnt       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_decoder.sv
// Scoreboard bench for seq_decoder (WIDTH=3).
// Expected results queued at acceptance, compared while presented.
module tb_seq_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] sel = '0;
  logic [1:0] mode = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] x;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       scan_wrap;

  typedef struct packed {
    logic [7:0] x;
    logic       wrap;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  logic mv = 1'b0;
  logic [2:0] mcnt = '0;

  always #5 clk = ~clk;

  seq_decoder #(.WIDTH(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .scan_wrap(scan_wrap)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] md,
                                 input logic [2:0] s,
                                 input logic [2:0] c);
    exp_t e;
    int   v;
    e.wrap = 1'b0;
    case (md)
      2'b00:   v = 1 << s;
      2'b01:   v = (2 << s) - 1;
      default: begin
        v = 1 << c;
        e.wrap = (c == 3'd7);
      end
    endcase
    e.x = v[7:0];
    return e;
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic iv, input logic [1:0] md,
                      input logic [2:0] s, input logic ordy);
    logic rdy;
    logic acc;
    in_valid  = iv;
    mode      = md;
    sel       = s;
    out_ready = ordy;
    #1;
    rdy = !mv || ordy;
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, mv);
    if (mv) begin
      chk("sb_depth", sbq.size(), 1);
      if (sbq.size() > 0) begin
        chk("x", x, sbq[0].x);
        chk("scan_wrap", scan_wrap, sbq[0].wrap);
        if (ordy) void'(sbq.pop_front());
      end
    end
    acc = iv && rdy;
    if (acc && md != 2'b11) begin
      sbq.push_back(model(md, s, mcnt));
      mv = 1'b1;
    end else if (ordy) begin
      mv = 1'b0;
    end
    if (acc && md == 2'b10) mcnt = mcnt + 3'd1;
    if (acc && md == 2'b11) mcnt = s;
    @(negedge clk);
  endtask

  task automatic reset_cycle(input logic iv);
    rst       = 1'b1;
    in_valid  = iv;
    mode      = 2'b00;
    sel       = 3'd3;
    out_ready = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    sbq.delete();
    mv   = 1'b0;
    mcnt = '0;
    chk("rst_x", x, 8'h00);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_wrap", scan_wrap, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    reset_cycle(1'b1);

    for (int i = 0; i < 8; i++) step(1'b1, 2'b00, 3'(i), 1'b1);
    chk("onehot7", x, 8'h80);
    step(1'b0, 2'b00, 3'd0, 1'b1);

    step(1'b1, 2'b01, 3'd0, 1'b1);
    chk("thermo0", x, 8'h01);
    step(1'b1, 2'b01, 3'd4, 1'b1);
    chk("thermo4", x, 8'h1F);
    step(1'b1, 2'b01, 3'd7, 1'b1);
    chk("thermo7", x, 8'hFF);
    step(1'b1, 2'b11, 3'd6, 1'b1);
    chk("load_drain", out_valid, 1'b0);

    step(1'b1, 2'b10, 3'd1, 1'b1);
    chk("scan6", x, 8'h40);
    step(1'b1, 2'b10, 3'd1, 1'b1);
    chk("scan7", x, 8'h80);
    chk("scan7_wrap", scan_wrap, 1'b1);
    step(1'b1, 2'b10, 3'd1, 1'b1);
    chk("scan0", x, 8'h01);
    chk("scan0_wrap", scan_wrap, 1'b0);

    step(1'b1, 2'b00, 3'd5, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 3'd2, 1'b0);
    chk("bp_hold", x, 8'h20);
    step(1'b1, 2'b00, 3'd2, 1'b1);
    chk("bp_new", x, 8'h04);
    step(1'b0, 2'b00, 3'd0, 1'b1);

    step(1'b1, 2'b11, 3'd5, 1'b1);
    step(1'b1, 2'b00, 3'd1, 1'b0);
    reset_cycle(1'b1);
    step(1'b1, 2'b10, 3'd4, 1'b1);
    chk("scan_after_rst", x, 8'h01);

    for (int i = 0; i < 1000; i++) begin
      logic [1:0] md;
      md = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      step(1'($urandom_range(0, 1)), md, 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 3) != 0));
    end
    step(1'b0, 2'b00, 3'd0, 1'b1);
    step(1'b0, 2'b00, 3'd0, 1'b1);
    chk("sb_final", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
